// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Holds the FSM state encoding and the nibble width.
package sub_pkg;

  localparam int NW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_4bit.sv
// 4-bit ripple-borrow subtractor: diff = x - y - bin.
// bout is the borrow out of bit 3.
module full_sub_4bit
  import sub_pkg::*;
(
  input  logic [NW-1:0] x,
  input  logic [NW-1:0] y,
  input  logic          bin,
  output logic [NW-1:0] diff,
  output logic          bout
);

  logic br;

  always_comb begin
    br   = bin;
    diff = '0;
    for (int i = 0; i < NW; i++) begin
      diff[i] = x[i] ^ y[i] ^ br;
      br      = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/nibble_sub_seq.sv
// Nibble-serial subtractor: one 4-bit slice per RUN cycle,
// result held in DONE until the consumer takes it.
module nibble_sub_seq
  import sub_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*NIB-1:0] d,
  output logic            bout,
  output logic            zero
);

  localparam int W  = NW * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            brw;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    d_q;
  logic            bout_q;
  logic            zero_q;

  logic [NW-1:0]   a_nib;
  logic [NW-1:0]   b_nib;
  logic [NW-1:0]   nib_d;
  logic            nib_bo;
  logic [W-1:0]    d_nx;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_q[NW*i +: NW];
        b_nib = b_q[NW*i +: NW];
      end
    end
  end

  full_sub_4bit u_sub (
    .x    (a_nib),
    .y    (b_nib),
    .bin  (brw),
    .diff (nib_d),
    .bout (nib_bo)
  );

  // d with the current nibble merged in; zero is judged on this
  always_comb begin
    d_nx = d_q;
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) begin
        d_nx[NW*i +: NW] = nib_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      brw    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          d_q <= d_nx;
          brw <= nib_bo;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            bout_q <= nib_bo;
            zero_q <= (d_nx == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign d         = d_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Bench for nibble_sub_seq: directed vector table, hand-written
// reset/abort sequence and randomized ops against an arithmetic model.
module tb_nibble_sub_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         zero;

  int n_chk  = 0;
  int n_fail = 0;

  nibble_sub_seq #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    int           hold;
    logic [W-1:0] ed;
    logic         eb;
    logic         ez;
  } vec_t;

  vec_t vecs[5];

  function automatic void check(string nm, logic [31:0] got,
                                logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  // Run one op; expected result comes from the caller.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input int hold, input bit tgl,
                       input logic [W-1:0] ed, input logic eb,
                       input logic ez, input string nm);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    a = ai;
    b = bi;
    bin = ci;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      if (tgl) begin
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
        in_valid = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'(NIB + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, " hold d"}, 32'(d), 32'(ed));
      check({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check({nm, " d"}, 32'(d), 32'(ed));
    check({nm, " bout"}, 32'(bout), 32'(eb));
    check({nm, " zero"}, 32'(zero), 32'(ez));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, " post in_ready"}, 32'(in_ready), 32'd1);
    check({nm, " post out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Model: plain wide arithmetic, borrow = minuend too small
  task automatic model_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input int hold, input bit tgl,
                          input string nm);
    logic [W-1:0] ed;
    logic         eb;
    int unsigned  ua;
    int unsigned  us;
    ua = 32'(ai);
    us = 32'(bi) + 32'(ci);
    ed = W'(ua - us);
    eb = (ua < us);
    do_op(ai, bi, ci, hold, tgl, ed, eb, (ed == '0), nm);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0100, 16'h0001, 1'b0, 0, 16'h00FF, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'hBEEF, 16'hBEEF, 1'b0, 3, 16'h0000, 1'b0, 1'b1};

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset d", 32'(d), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].hold, 1'b0,
            vecs[i].ed, vecs[i].eb, vecs[i].ez,
            $sformatf("vec%0d", i));
    end

    // abort mid-run with an asynchronous reset pulse
    @(negedge clk);
    a = 16'h1234;
    b = 16'h0234;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort d", 32'(d), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      check("abort no output", 32'(out_valid), 32'd0);
    end
    do_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0,
          16'h0002, 1'b0, 1'b0, "after abort");

    // inputs changing during RUN must not disturb the latched op
    model_op(16'hA5C3, 16'h3C5A, 1'b1, 0, 1'b1, "toggle0");
    model_op(16'h0F0F, 16'hF0F0, 1'b0, 2, 1'b1, "toggle1");

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      rc = 1'($urandom);
      model_op(ra, rb, rc, int'($urandom_range(0, 2)),
               1'($urandom), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_sub_seq.md
NIBBLE_SUB_SEQ -- requirements
Module: nibble_sub_seq

Interface
REQ-001 SHALL have parameter: NIB, default 4, number of 4-bit nibbles per operand (operand width W = 4*NIB).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operands a, b, bin valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports: a, b  input  W each  minuend and subtrahend, unsigned.
REQ-007 SHALL have port: bin  input  1  borrow-in into nibble 0.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: d  output  W  difference a - b - bin, modulo 2^W.
REQ-011 SHALL have port: bout  output  1  borrow-out of the top nibble.
REQ-012 SHALL have port: zero  output  1  high when d == 0.

Function
REQ-013 SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE, both decoded from registered state.
REQ-015 In IDLE with in_valid = 1, SHALL latch a, b, bin, clear nibble counter cnt to 0, and enter RUN; otherwise SHALL remain in IDLE.
REQ-016 In RUN, each cycle SHALL subtract nibble cnt of the latched operands with the registered borrow, write the result to d[4*cnt+3:4*cnt], and register the nibble borrow-out as the next borrow.
REQ-017 SHALL increment cnt by 1 per RUN cycle; at cnt == NIB-1 SHALL enter DONE and load bout from that nibble's borrow-out.
REQ-018 SHALL register zero on the same edge as the final nibble write, computed over the complete W-bit d.
REQ-019 Latency SHALL be exactly NIB+1 cycles from the accepting edge to out_valid = 1 (5 cycles for NIB = 4).
REQ-020 In DONE, d, bout and zero SHALL hold stable until out_ready = 1; on out_valid && out_ready the block SHALL return to IDLE on that edge.
REQ-021 There SHALL be no input/output overlap: a new operand is accepted no earlier than the cycle after the result handshake, so minimum spacing between accepts is NIB+2 cycles.
REQ-022 Changes on a, b, bin or in_valid during RUN or DONE SHALL be ignored.
REQ-023 out_ready while not in DONE SHALL have no effect.
REQ-024 d bits not yet written in RUN SHALL keep their previous values; d SHALL be observed only when out_valid = 1.

Reset
REQ-025 On rst = 1, regardless of clk, SHALL enter IDLE and clear cnt, the borrow register, the operand registers, d, bout and zero to 0.
REQ-026 Reset SHALL abort any in-progress subtraction with no output produced; after release, in_ready = 1 and out_valid = 0.

Structure
REQ-027 Package sub_pkg SHALL hold the FSM state encoding (IDLE = 0, RUN = 1, DONE = 2) and the nibble width constant 4.
REQ-028 The nibble arithmetic SHALL use exactly one instance of the team's existing 4-bit ripple-borrow subtractor (full_sub_4bit), with its borrow-in driven from the borrow register.
REQ-029 Nibble selection SHALL be a cnt-indexed mux on the latched operands; no W-bit subtractor SHALL be inferred.

Verification
REQ-030 a = 0x1234, b = 0x0234, bin = 0 -> d = 0x1000, bout = 0, zero = 0; out_valid rises exactly 5 cycles after the accept.
REQ-031 a = 0x0100, b = 0x0001, bin = 0 -> d = 0x00FF, bout = 0; borrow propagates across nibbles 0 and 1.
REQ-032 a = 0x0000, b = 0x0001, bin = 0 -> d = 0xFFFF, bout = 1; and a = 0x8000, b = 0x8000, bin = 1 -> d = 0xFFFF, bout = 1.
REQ-033 a = b = 0xBEEF, bin = 0 -> d = 0x0000, bout = 0, zero = 1; hold out_ready = 0 for 3 cycles -> outputs stable and in_ready = 0 throughout; out_ready = 1 -> in_ready = 1 on the next cycle.
REQ-034 Assert rst asynchronously mid-clock after 2 RUN cycles -> in_ready = 1, out_valid = 0 and d = 0 immediately; the next op a = 0x0005, b = 0x0003 -> d = 0x0002.
REQ-035 Toggle a, b and in_valid during RUN -> result matches the operands latched at the accept.
